// File: rtl/inst_queue.sv
// Instruction fetch queue: accepts in-order words from the memory controller, tracks the
// next fetch PC and presents a first-word-fall-through FIFO to the decoder. Optional macro:
// INST_QUEUE_BYPASS_EN (zero-latency bypass of a word arriving into an empty queue).
module inst_queue #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     mem_valid,
    input  logic [31:0]              mem_inst,
    input  logic [31:0]              mem_pc,
    output logic                     fetch_en,
    output logic [31:0]              fetch_pc,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    input  logic                     dec_ready,
    output logic                     dec_valid,
    output logic [31:0]              dec_inst,
    output logic [31:0]              dec_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] FETCH_MAX = CW'(DEPTH - 2);

`ifdef INST_QUEUE_BYPASS_EN
    localparam logic BYPASS_EN = 1'b1;
`else
    localparam logic BYPASS_EN = 1'b0;
`endif

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;

    logic [31:0]   inst_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];

    logic live;
    logic redirect_go;
    logic q_empty;
    logic q_full;
    logic accept;
    logic bypass_hit;
    logic bypass_take;
    logic q_pop;
    logic q_push;

    // Reset is folded in so nothing leaks to the outputs while rst is held low.
    assign live        = rst & rdy;
    assign redirect_go = live & redirect;
    assign q_empty     = (count_q == '0);
    assign q_full      = (count_q == FULL_CNT);

    // A redirect outranks everything: same-cycle deliveries and pops are ignored.
    assign accept      = live & ~redirect & mem_valid & (mem_pc == fetch_pc_q) & ~q_full;
    assign bypass_hit  = BYPASS_EN & q_empty & accept;
    assign bypass_take = bypass_hit & dec_ready;
    assign q_pop       = live & ~redirect & ~q_empty & dec_ready;
    assign q_push      = accept & ~bypass_take;

    assign fetch_en = live & ~redirect & (count_q <= FETCH_MAX);
    assign fetch_pc = fetch_pc_q;
    assign count    = count_q;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        dec_valid = 1'b0;
        dec_inst  = '0;
        dec_pc    = '0;
        if (!q_empty) begin
            dec_valid = 1'b1;
            dec_inst  = inst_mem[head_q];
            dec_pc    = pc_mem[head_q];
        end else if (bypass_hit) begin
            dec_valid = 1'b1;
            dec_inst  = mem_inst;
            dec_pc    = mem_pc;
        end
    end

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        fetch_pc_d = fetch_pc_q;
        if (redirect_go) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
        end else begin
            if (q_push) begin
                tail_d = tail_q + 1'b1;
            end
            if (q_pop) begin
                head_d = head_q + 1'b1;
            end
            if (accept) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            count_d = count_q + CW'(q_push) - CW'(q_pop);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            fetch_pc_q <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    // NOTE: storage is left unreset; count gates every read, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (q_push) begin
            inst_mem[tail_q] <= mem_inst;
            pc_mem[tail_q]   <= mem_pc;
        end
    end

    // Pointer/occupancy consistency: with natural wrap, tail - head equals count modulo DEPTH.
    always @(posedge clk) begin
        if (rst) begin
            assert (count_q <= FULL_CNT)
                else $error("inst_queue: count above DEPTH");
            assert (AW'(tail_q - head_q) == count_q[AW-1:0])
                else $error("inst_queue: pointers disagree with count");
        end
    end

endmodule
